// File: rtl/cpu_sequencer_if.sv
// cpu_sequencer_if: control bundle between the instruction sequencer and the CPU datapath/RAM.
// Ports (signals):
//   opcode  - IR opcode field, driven by the datapath
//   zero    - accumulator==0 flag, driven by the datapath
//   sel     - address mux select (1=PC, 0=IR operand)
//   rd, wr  - RAM read / write strobes
//   data_e  - AC drives the shared data bus
//   ld_ir, ld_ac, ld_pc, inc_pc - register load / increment enables
//   halt    - CPU halted
//   phase   - current sequencer phase (debug)
// Modports: master = sequencer (drives controls), slave = datapath (drives opcode/zero).
interface cpu_sequencer_if #(
    parameter int OPCODE_WIDTH = 3,
    parameter int PHASE_WIDTH  = 3
);
    logic [OPCODE_WIDTH-1:0] opcode;
    logic                    zero;
    logic                    sel;
    logic                    rd;
    logic                    wr;
    logic                    data_e;
    logic                    ld_ir;
    logic                    ld_ac;
    logic                    ld_pc;
    logic                    inc_pc;
    logic                    halt;
    logic [PHASE_WIDTH-1:0]  phase;

    modport master (
        input  opcode, zero,
        output sel, rd, wr, data_e, ld_ir, ld_ac, ld_pc, inc_pc, halt, phase
    );

    modport slave (
        output opcode, zero,
        input  sel, rd, wr, data_e, ld_ir, ld_ac, ld_pc, inc_pc, halt, phase
    );
endinterface

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: 8-phase fetch/execute controller for the 8-bit accumulator CPU.
// Ports:
//   clk   - system clock, state updates on rising edge
//   n_rst - asynchronous active-low reset
//   bus   - cpu_sequencer_if.master: opcode/zero in; sel, rd, wr, data_e,
//           ld_ir, ld_ac, ld_pc, inc_pc, halt, phase out
module cpu_sequencer #(
    parameter int OPCODE_WIDTH = 3,
    parameter int PHASE_WIDTH  = 3
) (
    input logic              clk,
    input logic              n_rst,
    cpu_sequencer_if.master  bus
);
    typedef enum logic [PHASE_WIDTH-1:0] {
        INST_ADDR, INST_FETCH, INST_LOAD, IDLE, OP_ADDR, OP_FETCH, ALU_OP, STORE
    } phase_t;

    localparam logic [OPCODE_WIDTH-1:0] OP_HLT = OPCODE_WIDTH'(0);
    localparam logic [OPCODE_WIDTH-1:0] OP_SKZ = OPCODE_WIDTH'(1);
    localparam logic [OPCODE_WIDTH-1:0] OP_ADD = OPCODE_WIDTH'(2);
    localparam logic [OPCODE_WIDTH-1:0] OP_AND = OPCODE_WIDTH'(3);
    localparam logic [OPCODE_WIDTH-1:0] OP_XOR = OPCODE_WIDTH'(4);
    localparam logic [OPCODE_WIDTH-1:0] OP_LDA = OPCODE_WIDTH'(5);
    localparam logic [OPCODE_WIDTH-1:0] OP_STO = OPCODE_WIDTH'(6);
    localparam logic [OPCODE_WIDTH-1:0] OP_JMP = OPCODE_WIDTH'(7);

    phase_t r_phase;
    logic   r_halted;
    phase_t w_phase_nxt;
    logic   w_halted_nxt;
    logic   w_hlt;
    logic   w_sto;
    logic   w_jmp;
    logic   w_skz;
    logic   w_aluop;
    logic   w_exec;

    assign w_hlt   = bus.opcode == OP_HLT;
    assign w_sto   = bus.opcode == OP_STO;
    assign w_jmp   = bus.opcode == OP_JMP;
    assign w_skz   = bus.opcode == OP_SKZ;
    assign w_aluop = bus.opcode inside {OP_ADD, OP_AND, OP_XOR, OP_LDA};
    // Operand-side phases where ALU ops keep the RAM read going and jumps/stores act
    assign w_exec  = r_phase inside {ALU_OP, STORE};
    assign bus.phase = r_phase;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_phase  <= INST_ADDR;
            r_halted <= 1'b0;
        end else begin
            r_phase  <= w_phase_nxt;
            r_halted <= w_halted_nxt;
        end
    end

    always_comb begin
        w_phase_nxt  = r_phase;
        w_halted_nxt = r_halted;
        bus.sel      = 1'b0;
        bus.rd       = 1'b0;
        bus.wr       = 1'b0;
        bus.data_e   = 1'b0;
        bus.ld_ir    = 1'b0;
        bus.ld_ac    = 1'b0;
        bus.ld_pc    = 1'b0;
        bus.inc_pc   = 1'b0;
        bus.halt     = r_halted || (r_phase == OP_ADDR && w_hlt);
        if (!r_halted) begin
            // HLT freezes the counter at OP_ADDR; the halted flag then masks every strobe
            w_halted_nxt = r_phase == OP_ADDR && w_hlt;
            w_phase_nxt  = w_halted_nxt ? r_phase : phase_t'(r_phase + 1'b1);
            bus.sel      = r_phase inside {INST_ADDR, INST_FETCH, INST_LOAD, IDLE};
            bus.rd       = r_phase inside {INST_FETCH, INST_LOAD, IDLE} ||
                           (w_aluop && r_phase inside {OP_FETCH, ALU_OP, STORE});
            bus.ld_ir    = r_phase inside {INST_LOAD, IDLE};
            bus.inc_pc   = (r_phase == OP_ADDR && !w_hlt) || (r_phase == ALU_OP && w_skz && bus.zero);
            bus.ld_pc    = w_exec && w_jmp;
            bus.data_e   = w_exec && w_sto;
            bus.wr       = r_phase == STORE && w_sto;
            bus.ld_ac    = r_phase == STORE && w_aluop;
        end
    end
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: self-checking bench for cpu_sequencer with a behavioural phase/halt model.
module tb_cpu_sequencer;
    logic clk = 1'b0;
    logic n_rst = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   m_phase = 0;
    bit   m_halted = 1'b0;
    logic [7:0] mem [0:255];

    cpu_sequencer_if #(.OPCODE_WIDTH(3), .PHASE_WIDTH(3)) bus ();

    cpu_sequencer #(.OPCODE_WIDTH(3), .PHASE_WIDTH(3)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    // Output order: sel rd wr data_e ld_ir ld_ac ld_pc inc_pc halt
    function automatic logic [8:0] model_out(int ph, bit hd, logic [2:0] op, logic z);
        bit alu = op inside {3'd2, 3'd3, 3'd4, 3'd5};
        bit sto = op == 3'd6;
        bit jmp = op == 3'd7;
        bit hlt = op == 3'd0;
        if (hd) return 9'b0_0000_0001;
        case (ph)
            0:       return 9'b1_0000_0000;
            1:       return 9'b1_1000_0000;
            2, 3:    return 9'b1_1001_0000;
            4:       return hlt ? 9'b0_0000_0001 : 9'b0_0000_0010;
            5:       return {1'b0, alu, 7'b0};
            6:       return {1'b0, alu, 1'b0, sto, 1'b0, 1'b0, jmp, (op == 3'd1) && z, 1'b0};
            default: return {1'b0, alu, sto, sto, 1'b0, alu, jmp, 1'b0, 1'b0};
        endcase
    endfunction

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            m_phase  <= 0;
            m_halted <= 1'b0;
        end else if (!m_halted) begin
            if (m_phase == 4 && bus.opcode == 3'd0) m_halted <= 1'b1;
            else m_phase <= (m_phase + 1) % 8;
        end
    end

    always @(posedge clk) if (bus.wr) mem[bus.sel ? 8'h00 : 8'h1A] <= bus.data_e ? 8'h5C : 8'hEE;

    always @(negedge clk) begin
        logic [8:0] act;
        logic [8:0] exp;
        act = {bus.sel, bus.rd, bus.wr, bus.data_e, bus.ld_ir, bus.ld_ac, bus.ld_pc, bus.inc_pc, bus.halt};
        exp = model_out(m_phase, m_halted, bus.opcode, bus.zero);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL outputs t=%0t phase=%0d op=%0d got=%b want=%b", $time, m_phase, bus.opcode, act, exp);
        end
        checks++;
        if (bus.phase !== 3'(m_phase)) begin
            errors++;
            $display("FAIL phase t=%0t got=%0d want=%0d", $time, bus.phase, m_phase);
        end
        checks++;
        if ((bus.rd && bus.wr) || (bus.wr && !bus.data_e) || (bus.data_e && bus.rd) || (bus.ld_pc && bus.inc_pc)) begin
            errors++;
            $display("FAIL invariant t=%0t got=%b want=no conflict", $time, act);
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    // Runs one full instruction starting at phase 0; bit i of each vector is the strobe in phase i
    task automatic run_cycle(input logic [2:0] op, input logic z,
                             output logic [7:0] rd_v, output logic [7:0] wr_v, output logic [7:0] de_v,
                             output logic [7:0] ir_v, output logic [7:0] ac_v, output logic [7:0] lp_v,
                             output logic [7:0] ip_v);
        bus.opcode = op;
        bus.zero   = z;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rd_v[i] = bus.rd;
            wr_v[i] = bus.wr;
            de_v[i] = bus.data_e;
            ir_v[i] = bus.ld_ir;
            ac_v[i] = bus.ld_ac;
            lp_v[i] = bus.ld_pc;
            ip_v[i] = bus.inc_pc;
        end
        @(posedge clk);
        #2;
    endtask

    task automatic reset_release();
        repeat (3) @(posedge clk);
        #2 n_rst = 1'b1;
    endtask

    initial begin
        logic [7:0] rd_v, wr_v, de_v, ir_v, ac_v, lp_v, ip_v;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        bus.opcode = 3'd2;
        bus.zero   = 1'b0;
        #1;
        chk("reset_sel_rd_wr", {5'b0, bus.sel, bus.rd, bus.wr}, 8'b0000_0100);
        chk("reset_phase", 8'(bus.phase), 8'h00);
        reset_release();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("phase_seq", 8'(bus.phase), 8'(i));
        end
        @(posedge clk);
        #2;
        chk("phase_wrap", 8'(bus.phase), 8'h00);

        run_cycle(3'd2, 1'b0, rd_v, wr_v, de_v, ir_v, ac_v, lp_v, ip_v);
        chk("add_rd", rd_v, 8'hEE);
        chk("add_ld_ir", ir_v, 8'h0C);
        chk("add_inc_pc", ip_v, 8'h10);
        chk("add_ld_ac", ac_v, 8'h80);
        chk("add_wr_de", wr_v | de_v, 8'h00);

        run_cycle(3'd6, 1'b0, rd_v, wr_v, de_v, ir_v, ac_v, lp_v, ip_v);
        chk("sto_data_e", de_v, 8'hC0);
        chk("sto_wr", wr_v, 8'h80);
        chk("sto_rd", rd_v, 8'h0E);
        chk("sto_ram_1a", mem[8'h1A], 8'h5C);

        run_cycle(3'd1, 1'b1, rd_v, wr_v, de_v, ir_v, ac_v, lp_v, ip_v);
        chk("skz_z1_inc", ip_v, 8'h50);
        run_cycle(3'd1, 1'b0, rd_v, wr_v, de_v, ir_v, ac_v, lp_v, ip_v);
        chk("skz_z0_inc", ip_v, 8'h10);
        run_cycle(3'd7, 1'b1, rd_v, wr_v, de_v, ir_v, ac_v, lp_v, ip_v);
        chk("jmp_ld_pc", lp_v, 8'hC0);
        chk("jmp_inc_pc", ip_v, 8'h10);

        // Asynchronous reset in the middle of the STO store phase
        bus.opcode = 3'd6;
        repeat (7) @(posedge clk);
        #2;
        chk("sto_p7_wr", {7'b0, bus.wr}, 8'h01);
        n_rst = 1'b0;
        #1;
        chk("async_wr", {7'b0, bus.wr}, 8'h00);
        chk("async_phase", 8'(bus.phase), 8'h00);
        chk("async_sel", {7'b0, bus.sel}, 8'h01);
        reset_release();

        // HLT: hold at phase 4 with everything quiet
        bus.opcode = 3'd0;
        repeat (4) @(posedge clk);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("hlt_phase", 8'(bus.phase), 8'h04);
            chk("hlt_flags", {bus.halt, bus.rd, bus.wr, bus.data_e, bus.ld_ir, bus.ld_ac, bus.ld_pc, bus.inc_pc}, 8'h80);
        end
        #2 n_rst = 1'b0;
        #1;
        chk("hlt_rst_phase", 8'(bus.phase), 8'h00);
        chk("hlt_rst_halt", {7'b0, bus.halt}, 8'h00);
        bus.opcode = 3'd2;
        reset_release();

        // Random non-halting traffic; opcode only changes at instruction boundaries
        for (int i = 0; i < 1000; i++) begin
            bus.zero = 1'($urandom);
            if (m_phase == 0) bus.opcode = 3'($urandom_range(1, 7));
            @(posedge clk);
            #2;
        end
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Instruction-cycle controller for the 8-bit accumulator CPU; it sits directly upstream of the program/data RAM. It steps through a fixed 8-phase fetch/execute cycle and generates the address-mux select, the RAM strobes (rd, wr, data_e), IR/AC/PC load enables, the PC increment and the halt indication. Strobe timing is matched to the RAM's one-cycle registered read and its posedge write.

Parameters:
OPCODE_WIDTH, 3, width of opcode field from IR (encodings below fixed for 3)
PHASE_WIDTH, 3, width of phase counter / debug output (8 phases)

Ports:
clk  input  1  system clock, all state updates on rising edge
n_rst  input  1  asynchronous active-low reset
opcode  input  OPCODE_WIDTH  IR opcode field; must be stable phases 4-7
zero  input  1  accumulator==0 flag from ALU
sel  output  1  address mux select: 1=PC, 0=IR operand address
rd  output  1  RAM read strobe
wr  output  1  RAM write strobe
data_e  output  1  enables AC drive onto shared data bus
ld_ir  output  1  IR load enable
ld_ac  output  1  accumulator load enable
ld_pc  output  1  PC load (jump) enable
inc_pc  output  1  PC increment enable
halt  output  1  CPU halted indication
phase  output  PHASE_WIDTH  current phase (debug)

Behaviour:
- Interface: one clock (clk); reset n_rst is asynchronous, active-low; all state clears immediately on n_rst=0, independent of clk.
- State: 3-bit phase counter plus sticky halted flag. Reset: phase=0, halted=0.
- Outputs are combinational decode of (phase, halted, opcode, zero); no other state.
- Reset values of outputs: sel=1, phase=0, all others 0.
- Opcodes: 0 HLT, 1 SKZ, 2 ADD, 3 AND, 4 XOR, 5 LDA, 6 STO, 7 JMP. ALUOP = ADD|AND|XOR|LDA.
- Phase sequence 0->1->...->7->0, one phase per clock, when not halted.
- Phase 0 INST_ADDR: sel=1.
- Phase 1 INST_FETCH: sel=1, rd=1 (RAM latches instruction at end of phase).
- Phase 2 INST_LOAD: sel=1, rd=1, ld_ir=1 (bus valid; IR captures).
- Phase 3 IDLE: sel=1, rd=1, ld_ir=1.
- Phase 4 OP_ADDR: sel=0, inc_pc=1 unless HLT; halt=1 if HLT.
- Phase 5 OP_FETCH: sel=0, rd=ALUOP.
- Phase 6 ALU_OP: sel=0, rd=ALUOP, inc_pc=(SKZ & zero), ld_pc=JMP, data_e=STO.
- Phase 7 STORE: sel=0, rd=ALUOP, ld_ac=ALUOP, ld_pc=JMP, wr=STO, data_e=STO.
- HLT: at end of phase 4 with opcode=HLT, set halted=1, phase holds at 4. While halted: halt=1, sel=0, all strobes 0, no PC increment. Exit only via reset.
- Invariants: rd and wr never both 1; wr=1 implies data_e=1; data_e=1 implies rd=0 (no bus contention with RAM); ld_pc and inc_pc never both 1.
- zero sampled combinationally in phase 6 only; ignored elsewhere. opcode ignored in phases 0-3.
- Reset mid-cycle (any phase, incl. mid-store): outputs return to reset values immediately; no wr asserted after n_rst falls; restart from phase 0 on first edge after release.

Test Plan:
- Reset: hold n_rst=0 3 cycles, release -> phase 0,1,2..7,0 on successive edges; during reset sel=1, rd=wr=0, phase=0.
- ADD (opcode=2) full cycle -> rd=1 in phases 1,2,3,5,6,7; ld_ir in 2,3; inc_pc in 4; ld_ac only in 7; wr/data_e never 1.
- STO (opcode=6) -> data_e=1 phases 6,7; wr=1 phase 7 only; rd=0 phases 5-7; RAM model at operand addr 0x1A holds AC value 0x5C after phase 7.
- SKZ with zero=1 -> inc_pc in phases 4 and 6 (PC advances by 2); with zero=0 -> inc_pc phase 4 only. JMP -> ld_pc in 6,7, inc_pc never with ld_pc.
- HLT (opcode=0) -> halt=1 from phase 4; phase stays 4 for 20 cycles, all strobes 0; n_rst pulse -> phase 0, halt=0.
- Assert n_rst=0 asynchronously between edges during STO phase 7 -> wr drops same time-step, phase=0; 1000 random opcode/zero cycles assert all invariants.
